// File: rtl/fetch_prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue_pkg
// Shared constants and types for the instruction prefetch queue:
//   XLEN_DEFAULT      datapath / address width
//   RESET_PC_DEFAULT  first fetch address after reset
//   NOP_INSTR         RV32I canonical NOP (addi x0,x0,0), shown when the head is empty
//   fetch_state_t     FETCH (issue/accept) / FLUSH (drain stale responses)
//   cnt_bits()        width of a counter that must hold 0..depth
// -----------------------------------------------------------------------------
package fetch_prefetch_queue_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_t;

  // Counter width able to represent every value from 0 to depth inclusive.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue_if
// Bundles the redirect input, the instruction-memory request/response port and
// the fetch-stage output port of the prefetch queue.
//   master : the prefetch queue (drives mem_req_*, instr_valid, InstrF, PCF, PCPlus4F)
//   slave  : the environment (execute-stage redirect, memory, fetch stage)
// -----------------------------------------------------------------------------
interface fetch_prefetch_queue_if
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;

  modport master (
    input  redirect, redirect_pc,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output instr_valid, InstrF, PCF, PCPlus4F,
    input  instr_ready
  );

  modport slave (
    output redirect, redirect_pc,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  instr_valid, InstrF, PCF, PCPlus4F,
    output instr_ready
  );

endinterface

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Synchronous circular FIFO with push/pop/clear and an occupancy count.
// Read data is taken from registered storage (no write-to-read bypass).
// Ports:
//   clk, rst (sync, active-low)  clock / reset
//   clear                        empties the FIFO (beats push and pop)
//   push, wdata                  write one entry (ignored when full without a pop)
//   pop                          discard the head (ignored when empty)
//   rdata                        head entry, meaningful when count != 0
//   count                        number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [cnt_bits(DEPTH)-1:0] count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against the current occupancy.
  always_comb begin
    do_pop  = pop && (count_q != {(AW+1){1'b0}});
    do_push = push && ((count_q != FULL_CNT) || do_pop);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= {AW{1'b0}};
      rd_ptr  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
    end else if (clear) begin
      wr_ptr  <= {AW{1'b0}};
      rd_ptr  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Entry storage; contents need no reset because count gates their use.
  always_ff @(posedge clk) begin
    if (rst && !clear && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
// Instruction prefetch queue for the fetch stage of a 5-stage RV32I core.
// Issues sequential word fetches, buffers returned words with their PCs and
// presents {InstrF, PCF, PCPlus4F} under decode back-pressure. An execute-stage
// redirect flushes the queue and discards responses still in flight.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active-low
//   bus (master)   redirect/redirect_pc, mem_req_* / mem_rsp_*, instr_* / InstrF / PCF / PCPlus4F
// Parameters: DEPTH (power of 2, >=2), XLEN, RESET_PC.
// Credit rule: entries held plus requests outstanding never exceed DEPTH, so a
// response always has room in the queue.
// -----------------------------------------------------------------------------
module fetch_prefetch_queue_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          mem_rsp_valid,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] discard
);

  // A response with nothing outstanding is a memory protocol violation.
  a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rst)
    mem_rsp_valid |-> (outstanding != {CW{1'b0}}));

  // Responses to discard are always a subset of those outstanding.
  a_discard_bounded: assert property (@(posedge clk) disable iff (!rst)
    discard <= outstanding);

endmodule

module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input logic                   clk,
  input logic                   rst,
  fetch_prefetch_queue_if.master bus
);

  localparam int              CW           = cnt_bits(DEPTH);
  localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK   = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_t      state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;

  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] head;
  logic [CW:0]       in_use;
  logic              req_valid;
  logic              req_fire;
  logic              head_valid;
  logic              push;
  logic              pop;
  logic [CW-1:0]     fire_inc;
  logic [CW-1:0]     rsp_dec;
  logic [CW-1:0]     redirect_discard;
  logic [XLEN-1:0]   redirect_base;

  // Issue/credit, queue control and redirect arithmetic.
  always_comb begin
    in_use     = {1'b0, fifo_count} + {1'b0, outstanding};
    req_valid  = rst && (state == ST_FETCH) && !bus.redirect && (in_use < CREDIT_LIMIT);
    req_fire   = req_valid && bus.mem_req_ready;
    head_valid = rst && (fifo_count != {CW{1'b0}});
    // Responses land in the queue only while fetching and never in a redirect cycle.
    push       = rst && (state == ST_FETCH) && bus.mem_rsp_valid && !bus.redirect;
    pop        = head_valid && bus.instr_ready && !bus.redirect;
    fire_inc   = {{(CW-1){1'b0}}, req_fire};
    rsp_dec    = {{(CW-1){1'b0}}, bus.mem_rsp_valid};
    // A response arriving in the redirect cycle is already dropped, so it is not counted.
    redirect_discard = outstanding - rsp_dec;
    redirect_base    = bus.redirect_pc & ALIGN_MASK;
  end

  // FETCH/FLUSH state machine with its PC and credit counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= {CW{1'b0}};
      discard     <= {CW{1'b0}};
    end else if (bus.redirect) begin
      fetch_pc    <= redirect_base;
      rsp_pc      <= redirect_base;
      outstanding <= redirect_discard;
      discard     <= redirect_discard;
      state       <= (redirect_discard != {CW{1'b0}}) ? ST_FLUSH : ST_FETCH;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      outstanding <= outstanding + fire_inc - rsp_dec;
      case (state)
        ST_FETCH: begin
          if (bus.mem_rsp_valid) begin
            rsp_pc <= rsp_pc + PC_STEP;
          end
        end
        ST_FLUSH: begin
          discard <= discard - rsp_dec;
          // Leave one cycle after the last stale response has been counted out.
          if (discard == {CW{1'b0}}) begin
            state <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.mem_rsp_data, rsp_pc}),
    .rdata (head),
    .count (fifo_count)
  );

  fetch_prefetch_queue_chk #(
    .CW (CW)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .mem_rsp_valid (bus.mem_rsp_valid),
    .outstanding   (outstanding),
    .discard       (discard)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.instr_valid   = head_valid;
  // An empty head shows a NOP so a careless consumer injects a harmless bubble.
  assign bus.InstrF        = head_valid ? head[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
  assign bus.PCF           = head[XLEN-1:0];
  assign bus.PCPlus4F      = head[XLEN-1:0] + PC_STEP;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_queue
// Self-checking bench: a cycle table for the warm-up/stall/redirect sequence,
// hand-written redirect/flush corner cases, a second instance with a wrapping
// reset PC, and randomized traffic against a stream-level reference model
// (requests and outputs must be consecutive words from the last redirect target,
// data must match the memory image).
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.XLEN(32)) bus  ();
  fetch_prefetch_queue_if #(.XLEN(32)) bus2 ();

  fetch_prefetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  fetch_prefetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct {
    bit redir; logic [31:0] rpc; bit irdy;
    bit e_rv; logic [31:0] e_addr; bit e_iv; logic [31:0] e_pc;
  } vec_t;

  pend_t       pend[$];
  int          cyc, last_due, lat_min, lat_max;
  int          errors, checks, fires, pops, rsps;
  logic [31:0] exp_req_pc, exp_out_pc, prev_addr, last_fire_addr, last_pop_pc;
  bit          prev_hold;
  bit          s_rv, s_iv;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;
  bit          r2_valid, b2_irdy;
  logic [31:0] r2_addr;
  logic [31:0] q2_addr[$];
  logic [31:0] q2_pc[$];
  logic [31:0] q2_pc4[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs and memory, sample, check the stream model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit irdy);
    int lat, due;
    @(negedge clk);
    bus.redirect = redir; bus.redirect_pc = rpc;
    bus.mem_req_ready = rdy; bus.instr_ready = irdy;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = memfn(pend[0].addr);
      void'(pend.pop_front()); rsps++;
    end else begin
      bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = $urandom;
    end
    bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0; bus2.mem_req_ready = 1'b1;
    bus2.instr_ready = b2_irdy; bus2.mem_rsp_valid = r2_valid; bus2.mem_rsp_data = memfn(r2_addr);
    #1;
    s_rv = bus.mem_req_valid; s_addr = bus.mem_req_addr; s_iv = bus.instr_valid;
    s_instr = bus.InstrF; s_pc = bus.PCF; s_pc4 = bus.PCPlus4F;
    if (redir) chk("req_valid_in_redirect", 32'(s_rv), 32'd0);
    if (prev_hold && !redir) begin
      chk("req_hold_valid", 32'(s_rv), 32'd1);
      chk("req_hold_addr", s_addr, prev_addr);
    end
    if (s_rv && rdy) begin
      chk("req_addr", s_addr, exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
      fires++; last_fire_addr = s_addr;
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: s_addr, due: due});
    end
    if (s_iv && irdy && !redir) begin
      chk("out_pc", s_pc, exp_out_pc);
      chk("out_instr", s_instr, memfn(exp_out_pc));
      chk("out_pc4", s_pc4, exp_out_pc + 32'd4);
      last_pop_pc = s_pc; exp_out_pc = exp_out_pc + 32'd4; pops++;
    end
    if (redir) begin
      exp_req_pc = rpc & 32'hFFFF_FFFC;
      exp_out_pc = rpc & 32'hFFFF_FFFC;
    end
    prev_hold = s_rv && !rdy;
    prev_addr = s_addr;
    r2_valid = bus2.mem_req_valid; r2_addr = bus2.mem_req_addr;
    if (bus2.mem_req_valid) q2_addr.push_back(bus2.mem_req_addr);
    if (bus2.instr_valid && b2_irdy) begin
      q2_pc.push_back(bus2.PCF); q2_pc4.push_back(bus2.PCPlus4F);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.mem_req_ready = 1'b0;
    bus.instr_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 32'h0;
    bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0; bus2.mem_req_ready = 1'b0;
    bus2.instr_ready = 1'b0; bus2.mem_rsp_valid = 1'b0; bus2.mem_rsp_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      @(negedge clk);
    end
    pend.delete(); last_due = cyc; prev_hold = 1'b0;
    exp_req_pc = 32'h0; exp_out_pc = 32'h0;
    fires = 0; pops = 0; rsps = 0;
    r2_valid = 1'b0; r2_addr = 32'h0; b2_irdy = 1'b0;
    q2_addr.delete(); q2_pc.delete(); q2_pc4.delete();
    rst = 1'b1;
  endtask

  task automatic run_until_pop(input int budget, input string name, input logic [31:0] exp_pc);
    int p0;
    p0 = pops;
    for (int i = 0; i < budget && pops == p0; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    if (pops == p0) chk({name, "_timeout"}, 32'(pops - p0), 32'd1);
    else            chk(name, last_pop_pc, exp_pc);
  endtask

  task automatic run_until_fire(input int budget, input string name, input logic [31:0] exp_addr);
    int f0;
    f0 = fires;
    for (int i = 0; i < budget && fires == f0; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    if (fires == f0) chk({name, "_timeout"}, 32'(fires - f0), 32'd1);
    else             chk(name, last_fire_addr, exp_addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[17];
    int   r0;
    errors = 0; checks = 0; cyc = 0; lat_min = 1; lat_max = 1;
    b2_irdy = 1'b0; r2_valid = 1'b0; r2_addr = 32'h0;
    //        redir rpc           irdy rv  addr          iv  pc
    tbl[0]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h000, 1'b0, 32'h000};
    tbl[1]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h004, 1'b0, 32'h000};
    tbl[2]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h008, 1'b1, 32'h000};
    tbl[3]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h00C, 1'b1, 32'h004};
    tbl[4]  = '{1'b0, 32'h0,      1'b0, 1'b1, 32'h010, 1'b1, 32'h008};
    tbl[5]  = '{1'b0, 32'h0,      1'b0, 1'b1, 32'h014, 1'b1, 32'h008};
    tbl[6]  = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h000, 1'b1, 32'h008};
    tbl[7]  = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h000, 1'b1, 32'h008};
    tbl[8]  = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h000, 1'b1, 32'h008};
    tbl[9]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h000, 1'b1, 32'h008};
    tbl[10] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h018, 1'b1, 32'h00C};
    tbl[11] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h01C, 1'b1, 32'h010};
    tbl[12] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h020, 1'b1, 32'h014};
    tbl[13] = '{1'b1, 32'h103,    1'b1, 1'b0, 32'h000, 1'b1, 32'h018};
    tbl[14] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h100, 1'b0, 32'h000};
    tbl[15] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
    tbl[16] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h108, 1'b1, 32'h100};

    // Table: warm-up, stall to full credit, release, redirect with same-cycle response.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].redir, tbl[i].rpc, 1'b1, tbl[i].irdy);
      chk($sformatf("tbl%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_instr_valid", i), 32'(s_iv), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        chk($sformatf("tbl%0d_pcf", i), s_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_pcplus4", i), s_pc4, tbl[i].e_pc + 32'd4);
        chk($sformatf("tbl%0d_instr", i), s_instr, memfn(tbl[i].e_pc));
      end
    end

    // Long stall: exactly DEPTH requests, then release without loss or duplication.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_fires", 32'(fires), 32'd4);
    chk("stall_req_valid", 32'(s_rv), 32'd0);
    chk("stall_instr_valid", 32'(s_iv), 32'd1);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_release_pops", 32'(pops >= 8), 32'd1);

    // Redirect with 3 responses outstanding at latency 5.
    do_reset();
    lat_min = 5; lat_max = 5;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t3_outstanding", 32'(fires), 32'd3);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    r0 = rsps;
    run_until_fire(30, "t3_first_addr", 32'h100);
    chk("t3_stale_drained", 32'(rsps - r0), 32'd3);
    run_until_pop(30, "t3_first_pc", 32'h100);

    // Redirect to an unaligned target in the same cycle as a response.
    do_reset();
    lat_min = 1; lat_max = 1;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h203, 1'b1, 1'b1);
    chk("t4_rsp_in_redirect", 32'(bus.mem_rsp_valid), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t4_req_valid", 32'(s_rv), 32'd1);
    chk("t4_req_addr", s_addr, 32'h200);
    chk("t4_no_stale_out", 32'(s_iv), 32'd0);
    run_until_pop(10, "t4_first_pc", 32'h200);

    // Second redirect while flushing.
    do_reset();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    r0 = rsps;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h40, 1'b1, 1'b1);
    run_until_fire(30, "t5_first_addr", 32'h40);
    chk("t5_stale_drained", 32'(rsps - r0), 32'd3);
    run_until_pop(30, "t5_first_pc", 32'h40);

    // Address wrap on the second instance (reset PC near the top of memory).
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap_req_count", 32'(q2_addr.size()), 32'd4);
    if (q2_addr.size() >= 3) begin
      chk("wrap_addr0", q2_addr[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", q2_addr[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", q2_addr[2], 32'h0000_0000);
    end
    b2_irdy = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap_pop_count", 32'(q2_pc.size() >= 3), 32'd1);
    if (q2_pc.size() >= 3) begin
      chk("wrap_pc0", q2_pc[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", q2_pc[1], 32'hFFFF_FFFC);
      chk("wrap_pc1_plus4", q2_pc4[1], 32'h0000_0000);
      chk("wrap_pc2", q2_pc[2], 32'h0000_0000);
    end

    // Randomized traffic against the stream model.
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      bit          rd;
      logic [31:0] tgt;
      rd  = ($urandom_range(99, 0) < 3);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                         : ($urandom & 32'h0000_0FFF);
      step(rd, tgt, ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
    end
    chk("random_progress", 32'(pops > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
